// File: rtl/score_tracker.sv
// score_tracker: combo-multiplied score accumulator with saturation, frame-latched display copy
// and optional high score (SCORE_HIGHSCORE_EN builds the high-score register and new_high flag).
module score_tracker #(
  parameter int MAX_SCORE    = 65535,
  parameter int COMBO_WINDOW = 60,
  parameter int COMBO_MAX    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        add_valid,
  input  logic [7:0]  add_points,
  input  logic        frame_tick,
  output logic [15:0] score,
  output logic [15:0] live_score,
  output logic [2:0]  combo,
  output logic [15:0] high_score,
  output logic        new_high
);
  localparam logic [16:0] MAX17 = 17'(MAX_SCORE);
  localparam logic [15:0] MAX16 = 16'(MAX_SCORE);
  localparam logic [7:0]  CW8   = 8'(COMBO_WINDOW);
  localparam logic [2:0]  CM3   = 3'(COMBO_MAX);
  logic [15:0] acc_q, acc_d, score_q, score_d;
  logic [7:0]  win_q, win_d;
  logic [2:0]  combo_q, combo_d;
  logic        hit;
  logic [10:0] prod;
  logic [16:0] sum;
  // a zero-point hit is a full no-op, so it must not count as accepted
  assign hit  = add_valid && (add_points != 8'd0);
  assign prod = 11'(add_points) * 11'(combo_q);
  assign sum  = 17'(acc_q) + 17'(prod);
  always_comb begin
    acc_d   = clear ? 16'd0 : hit ? ((sum > MAX17) ? MAX16 : sum[15:0]) : acc_q;
    score_d = clear ? 16'd0 : frame_tick ? acc_q : score_q;
    win_d   = clear ? 8'd0 : hit ? CW8 : (frame_tick && win_q != 8'd0) ? win_q - 8'd1 : win_q;
    combo_d = clear ? 3'd1 : hit ? ((combo_q < CM3) ? combo_q + 3'd1 : combo_q) :
              (frame_tick && win_q == 8'd1) ? 3'd1 : combo_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= 16'd0;
      score_q <= 16'd0;
      win_q   <= 8'd0;
      combo_q <= 3'd1;
    end else begin
      acc_q   <= acc_d;
      score_q <= score_d;
      win_q   <= win_d;
      combo_q <= combo_d;
    end
  end
  assign score      = score_q;
  assign live_score = acc_q;
  assign combo      = combo_q;
`ifdef SCORE_HIGHSCORE_EN
  logic [15:0] high_q, high_d;
  logic        new_high_q, new_high_d, beat;
  // compares the registered accumulator, so the high score trails live_score by one cycle
  assign beat = acc_q > high_q;
  always_comb begin
    high_d     = beat ? acc_q : high_q;
    new_high_d = clear ? 1'b0 : (beat | new_high_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      high_q     <= 16'd0;
      new_high_q <= 1'b0;
    end else begin
      high_q     <= high_d;
      new_high_q <= new_high_d;
    end
  end
  assign high_score = high_q;
  assign new_high   = new_high_q;
`else
  assign high_score = 16'd0;
  assign new_high   = 1'b0;
`endif
endmodule

// File: doc/score_tracker.md
# score_tracker

Game-side score accumulator that produces the 16-bit binary `score` consumed by `score_display`. It adds hit points with a combo multiplier, saturates at a configurable ceiling, and keeps a high score. It presents the display copy only on frame boundaries so the rendered number never changes mid-frame. It sits between the game logic (hit/event pulses) and the VGA score overlay, in the pixel-clock domain.

## Interface
Parameters:
- `MAX_SCORE`, 65535 — saturation ceiling for the accumulator (≤ 65535).
- `COMBO_WINDOW`, 60 — frames a combo survives without a new hit (1..255).
- `COMBO_MAX`, 4 — maximum multiplier (1..7).

Ports:
- `clk`  in  1  — system/pixel clock; one clock domain only.
- `reset`  in  1  — synchronous, active-high; clears all state including high score.
- `clear`  in  1  — synchronous game restart pulse; high score is retained.
- `add_valid`  in  1  — one-cycle hit event.
- `add_points`  in  8  — base points of the hit; sampled when `add_valid`=1.
- `frame_tick`  in  1  — one-cycle pulse at start of vertical blank.
- `score`  out  16  — display copy; updates only on `frame_tick`.
- `live_score`  out  16  — accumulator value, updated every cycle.
- `combo`  out  3  — current multiplier (1..`COMBO_MAX`).
- `high_score`  out  16  — best score since reset.
- `new_high`  out  1  — sticky flag: current game has beaten the prior high score.

## Operation
- Accumulator update: if `add_valid` and `add_points` ≠ 0, then `acc <= min(acc + add_points*combo, MAX_SCORE)`.
  - Product is 11 bits; the sum is computed in 17 bits before saturation; no wrap-around is permitted.
  - `add_points`=0 with `add_valid`=1 is a full no-op: no score change, no combo change, no window reload.
- Combo state:
  - Counter `win` (8 bits) and multiplier `combo`.
  - Accepted hit: `combo <= min(combo+1, COMBO_MAX)` (the hit itself uses the old `combo`); `win <= COMBO_WINDOW`.
  - `frame_tick` with `win` ≠ 0 and no accepted hit: `win <= win-1`. When it decrements 1→0, `combo <= 1`.
  - Accepted hit and `frame_tick` in the same cycle: reload wins; no decrement.
- Display latch: on `frame_tick`, `score <= acc`, using the registered value before any same-cycle add.
- High score: each cycle, if `acc > high_score`, then `high_score <= acc` and `new_high <= 1`. Equal does not set the flag.
- `clear`: `acc`, `score`, `win` ← 0; `combo` ← 1; `new_high` ← 0; `high_score` is kept.
  - Priority: `reset` > `clear` > `add_valid`. A same-cycle add is discarded.
  - `clear` with `frame_tick` gives `score`=0.

## Timing
- Reset values: `score`=0, `live_score`=0, `combo`=1, `high_score`=0, `new_high`=0, `win`=0.
- Hit sampled at edge N → `live_score`/`combo` valid after edge N. `high_score`/`new_high` valid after edge N+1.
- `score` changes only at an edge where `frame_tick`=1; latency from a hit is up to one frame.
- Back-to-back `add_valid` on consecutive cycles is fully supported: one hit per cycle, no stall, no handshake.
- Reset mid-combo or mid-frame takes effect at the next edge and discards all in-flight state.

## Configuration
- `SCORE_HIGHSCORE_EN` defined: high-score register, comparator, and `new_high` are built as described.
- Not defined: `high_score` is tied to 16'd0 and `new_high` to 0; no high-score logic is synthesized. Accumulator and combo behaviour are unchanged.

## Test plan
- Combo build: reset; hits of 10, 10, 10 on separate cycles within the window → `live_score` 10, 30, 60; `combo` 2, 3, 4; a 4th hit of 10 → 100 with `combo` staying 4.
- Combo expiry: one hit of 10, then 60 `frame_tick`s → `combo`=1 after the 60th tick; next hit of 10 → `live_score`=20.
- Saturation: drive `acc` to 65530 with `combo`=1, then hit of 20 → `live_score`=65535; a further hit keeps it at 65535.
- Frame latch: `acc`=50, hit of 5 coincident with `frame_tick` → `score`=50 and `live_score`=55; the next `frame_tick` → `score`=55.
- Clear priority: `clear` with `add_valid` (`add_points`=40) → `live_score`=0, `combo`=1, `score`=0 next cycle.
- High score (macro defined): reach 500, `clear`, reach 300 → `high_score`=500, `new_high`=0; reach 600 → `high_score`=600, `new_high`=1. With the macro undefined → `high_score`=0 and `new_high`=0 throughout.
